atan: RTL and testbench

- Inverse-trigonometry ALU op for the calculator datapath: takes a BF16 operand and returns arctan(a) in degrees, encoded as BF16.
- Pairs with the existing tan op, running in the opposite direction (BF16 in, degrees out).
- Self-contained: BF16 unpack, CORDIC vectoring with a degree-domain angle table, and fixed-to-BF16 pack. No submodule handshakes.
- Sits beside the other ALU ops and uses the same start/done/error contract.

---
 rtl/atan_if.sv | 27 ++
 rtl/atan.sv | 207 ++++++++++++++++++++
 tb/tb_atan.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/atan_if.sv
// rtl/atan_if.sv - start/done request bus carrying the BF16 operand and arctan result
interface atan_if;
  logic        start;
  logic [15:0] a;
  logic [15:0] result;
  logic        error;
  logic        done;
  logic        busy;

  modport master (
    output start,
    output a,
    input  result,
    input  error,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  a,
    output result,
    output error,
    output done,
    output busy
  );
endinterface

// File: rtl/atan.sv
// rtl/atan.sv - BF16 arctan in degrees via CORDIC vectoring with a degree-domain angle table
module atan #(
  parameter int ITER = 16,
  parameter int FRAC = 22
) (
  input logic   clk,
  input logic   rst,
  atan_if.slave bus
);

  localparam int                IW       = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic signed [31:0] Z_MAX    = 32'sd90 <<< FRAC;
  localparam logic signed [9:0]  FRAC_E   = 10'(FRAC);
  localparam logic signed [9:0]  MSH      = 10'(FRAC - 7);
  localparam logic [7:0]         EXP_BIAS = 8'(127 - FRAC);

  typedef enum logic [2:0] {IDLE, UNPACK, ITERATE, PACK, OUTPUT} state_t;

  state_t             state, state_next;
  logic [15:0]        a_q;
  logic               sign_q;
  logic signed [31:0] x_q, y_q, z_q;
  logic [IW-1:0]      iter_q;
  logic [15:0]        result_q;
  logic               error_q, done_q, busy_q;

  logic [7:0]         exp_f;
  logic [6:0]         frac_f;
  logic signed [9:0]  e_s, ysh;
  logic [4:0]         xsh;
  logic               is_nan, is_sat, special;
  logic [15:0]        special_result;
  logic [31:0]        mant32;
  logic signed [31:0] x_init, y_init;

  logic signed [31:0] shx, shy, x_nx, y_nx, z_nx;

  logic signed [31:0] zc;
  logic [4:0]         lead;
  logic [31:0]        norm;
  logic [7:0]         top, msum, pack_exp;
  logic [15:0]        pack_result;

  // atan(2^-i) in degrees scaled by 2^22; entries beyond 15 contribute nothing
  function automatic logic signed [31:0] atan_tab(input int i);
    case (i)
      0:       return 32'sd188743680;
      1:       return 32'sd111421900;
      2:       return 32'sd58872272;
      3:       return 32'sd29884485;
      4:       return 32'sd15000234;
      5:       return 32'sd7507429;
      6:       return 32'sd3754631;
      7:       return 32'sd1877430;
      8:       return 32'sd938729;
      9:       return 32'sd469366;
      10:      return 32'sd234683;
      11:      return 32'sd117342;
      12:      return 32'sd58671;
      13:      return 32'sd29335;
      14:      return 32'sd14668;
      15:      return 32'sd7334;
      default: return 32'sd0;
    endcase
  endfunction

  // Decode the latched operand: special-case classification and CORDIC prescale
  always_comb begin
    exp_f  = a_q[14:7];
    frac_f = a_q[6:0];
    e_s    = $signed({2'b00, exp_f}) - 10'sd127;
    is_nan = (exp_f == 8'hFF) && (frac_f != 7'd0);
    is_sat = !is_nan && ((exp_f == 8'hFF) || (e_s > 10'sd28));
    special = is_nan || is_sat || (exp_f == 8'd0) || (e_s < -10'sd20);
    special_result = 16'h0000;
    if (is_nan) begin
      special_result = 16'hFFC0;
    end else if (is_sat) begin
      special_result = a_q[15] ? 16'hC2B4 : 16'h42B4;
    end
    mant32 = {24'd0, 1'b1, frac_f};
    ysh    = e_s + MSH;
    xsh    = 5'(FRAC_E - e_s);
    if (e_s >= 0) begin
      // Large operands: keep y at full scale and shrink x; beyond FRAC x vanishes and the angle tends to 90
      y_init = $signed(mant32 << MSH[4:0]);
      x_init = (e_s > FRAC_E) ? 32'sd0 : $signed(32'd1 << xsh);
    end else begin
      // Small operands: x stays at 1.0 and y is scaled down, dropping bits below the LSB
      y_init = (ysh >= 0) ? $signed(mant32 << 5'(ysh)) : $signed(mant32 >> 5'(-ysh));
      x_init = $signed(32'd1 << FRAC_E[4:0]);
    end
  end

  // One CORDIC vectoring micro-rotation, driving y toward zero
  always_comb begin
    shx = x_q >>> iter_q;
    shy = y_q >>> iter_q;
    if (!y_q[31]) begin
      x_nx = x_q + shy;
      y_nx = y_q - shx;
      z_nx = z_q + atan_tab(int'(iter_q));
    end else begin
      x_nx = x_q - shy;
      y_nx = y_q + shx;
      z_nx = z_q - atan_tab(int'(iter_q));
    end
  end

  // Clamp the accumulated angle and round it to BF16 (half-up on the bit below the mantissa)
  always_comb begin
    if (z_q < 0) begin
      zc = 32'sd0;
    end else if (z_q > Z_MAX) begin
      zc = Z_MAX;
    end else begin
      zc = z_q;
    end
    lead = 5'd0;
    for (int k = 0; k < 32; k++) begin
      if (zc[k]) lead = 5'(k);
    end
    norm     = zc << (5'd31 - lead);
    top      = 8'(norm >> 23);
    msum     = {1'b0, top[7:1]} + {7'd0, top[0]};
    pack_exp = EXP_BIAS + {3'd0, lead} + {7'd0, msum[7]};
    pack_result = (zc == 32'sd0) ? 16'h0000 : {sign_q, pack_exp, msum[6:0]};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; a start coinciding with the done pulse is not accepted
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start && !done_q) state_next = UNPACK;
      UNPACK:  state_next = special ? OUTPUT : ITERATE;
      ITERATE: if (iter_q == IW'(ITER - 1)) state_next = PACK;
      PACK:    state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= 16'h0000;
      sign_q   <= 1'b0;
      x_q      <= 32'sd0;
      y_q      <= 32'sd0;
      z_q      <= 32'sd0;
      iter_q   <= '0;
      result_q <= 16'h0000;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !done_q) begin
            a_q     <= bus.a;
            error_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        UNPACK: begin
          sign_q <= a_q[15];
          iter_q <= '0;
          if (special) begin
            result_q <= special_result;
            error_q  <= is_nan;
          end else begin
            x_q <= x_init;
            y_q <= y_init;
            z_q <= 32'sd0;
          end
        end
        ITERATE: begin
          x_q    <= x_nx;
          y_q    <= y_nx;
          z_q    <= z_nx;
          iter_q <= iter_q + IW'(1);
        end
        PACK: begin
          result_q <= pack_result;
        end
        OUTPUT: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.error  = error_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_atan.sv
// tb/tb_atan.sv - directed and randomized self-checking bench for atan
module tb_atan;
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  atan_if bus ();

  atan #(.ITER(16), .FRAC(22)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] d_a [10] = '{16'h3F80, 16'hBF80, 16'h4000, 16'h3FDE, 16'h0000,
                            16'h7F80, 16'hFF80, 16'h7FC1, 16'h4F80, 16'h3300};
  logic [15:0] d_r [10] = '{16'h4234, 16'hC234, 16'h427E, 16'h4270, 16'h0000,
                            16'h42B4, 16'hC2B4, 16'hFFC0, 16'h42B4, 16'h0000};
  int          d_l [10] = '{19, 19, 19, 19, 2, 2, 2, 2, 2, 2};
  logic        d_e [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
    int d;
    d = obs - exp;
    if (d < 0) d = -d;
    n_checks++;
    if (d <= tol) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d", tag, obs, obs, exp, exp, tol);
  endtask

  function automatic int bf_ord(input logic [15:0] b);
    return b[15] ? -int'(b[14:0]) : int'(b[14:0]);
  endfunction

  function automatic logic [15:0] to_bf16(input real v);
    real m;
    int  ex;
    int  mi;
    if (v <= 0.0) return 16'h0000;
    m  = v;
    ex = 0;
    while (m >= 2.0) begin m = m / 2.0; ex++; end
    while (m < 1.0)  begin m = m * 2.0; ex--; end
    mi = int'($floor(m * 128.0 + 0.5));
    if (mi == 256) begin mi = 128; ex++; end
    return {1'b0, 8'(ex + 127), 7'(mi - 128)};
  endfunction

  task automatic model(input logic [15:0] op, output logic [15:0] r, output logic err,
                       output int lat, output bit exact);
    int  ex, e, fr;
    real v, deg;
    ex = int'(op[14:7]);
    fr = int'(op[6:0]);
    e  = ex - 127;
    r = 16'h0000; err = 1'b0; lat = 2; exact = 1'b1;
    if (ex == 255 && fr != 0) begin
      r = 16'hFFC0; err = 1'b1;
    end else if (ex == 255 || e > 28) begin
      r = op[15] ? 16'hC2B4 : 16'h42B4;
    end else if (ex == 0 || e < -20) begin
      r = 16'h0000;
    end else begin
      v   = (1.0 + real'(fr) / 128.0) * $pow(2.0, real'(e));
      deg = $atan(v) * 180.0 / PI;
      r   = to_bf16(deg);
      r[15] = op[15];
      lat = 19;
      exact = 1'b0;
    end
  endtask

  task automatic run_op(input logic [15:0] op, output logic [15:0] r, output logic err,
                        output int lat, output int busy_n);
    @(negedge clk);
    bus.a = op;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat <= 18 && bus.busy) busy_n++;
    end
    r   = bus.result;
    err = bus.error;
    check("busy_at_done", int'(bus.busy), 0);
  endtask

  initial begin
    logic [15:0] r, nr, a, er;
    logic        err, eerr;
    int          lat, elat, bn, dones, dn, bcnt, ex;
    bit          exact;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_result", int'(bus.result), 0);
    check("rst_error", int'(bus.error), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(d_a[i], r, err, lat, bn);
      check($sformatf("dir_res_%h", d_a[i]), int'(r), int'(d_r[i]));
      check($sformatf("dir_err_%h", d_a[i]), int'(err), int'(d_e[i]));
      check($sformatf("dir_lat_%h", d_a[i]), lat, d_l[i]);
      if (d_l[i] == 19) check($sformatf("dir_busy_%h", d_a[i]), bn, 18);
    end

    // second start while busy must be dropped
    @(negedge clk);
    bus.a = 16'h3F80;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    dones = 0; dn = 0; bcnt = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (bus.done) begin dones++; dn = n; end
      if (n <= 18 && bus.busy) bcnt++;
      bus.start = (n == 5);
      if (n == 5) bus.a = 16'h4000;
    end
    bus.start = 1'b0;
    check("hs_dones", dones, 1);
    check("hs_done_cycle", dn, 19);
    check("hs_busy_cycles", bcnt, 18);
    check("hs_result", int'(bus.result), 16'h4234);

    // start coinciding with done is ignored, done lasts one cycle
    run_op(16'h4000, r, err, lat, bn);
    bus.a = 16'h3F80;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("done_one_cycle", int'(bus.done), 0);
    check("start_at_done_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("start_at_done_idle", int'(bus.busy), 0);
    check("result_held", int'(bus.result), 16'h427E);

    // start on the cycle right after done is accepted
    run_op(16'h4000, r, err, lat, bn);
    run_op(16'h3FDE, r, err, lat, bn);
    check("b2b_result", int'(r), 16'h4270);
    check("b2b_lat", lat, 19);

    // reset during iteration i=8 aborts without done
    @(negedge clk);
    bus.a = 16'h3F80;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_result", int'(bus.result), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_error", int'(bus.error), 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("midrst_no_done", dones, 0);
    run_op(16'h4000, r, err, lat, bn);
    check("postrst_result", int'(r), 16'h427E);
    check("postrst_lat", lat, 19);

    // randomized operands against the real-arithmetic model
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 16'($urandom);
      end else begin
        int e;
        e = int'($urandom_range(0, 29)) - 5;
        a = {1'($urandom_range(0, 1)), 8'(e + 127), 7'($urandom_range(0, 127))};
      end
      model(a, er, eerr, elat, exact);
      run_op(a, r, err, lat, bn);
      check($sformatf("rnd_lat_%h", a), lat, elat);
      check($sformatf("rnd_err_%h", a), int'(err), int'(eerr));
      ex = int'(a[14:7]) - 127;
      if (exact) begin
        check($sformatf("rnd_res_%h", a), int'(r), int'(er));
      end else if (ex >= -5) begin
        check($sformatf("rnd_ulp_%h", a), bf_ord(r), bf_ord(er), 1);
        run_op(a ^ 16'h8000, nr, err, lat, bn);
        check($sformatf("rnd_sym_%h", a), int'(nr), int'(r ^ 16'h8000));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
